noc_link_tx: RTL and testbench

Credit-based flit transmitter that drives one NoC link into a downstream router input `circular_buffer`. It accepts flits from a local source (router output stage or PE/GLB port) through a valid/ready handshake and keeps a credit count mirroring free slots in the downstream buffer. It issues `link_write_en_o` only when a slot is guaranteed free, so the downstream buffer never sees a write while full. It tracks packet boundaries so a packet, once started, owns the link until its tail flit.

---
 rtl/noc_link_tx.sv | 151 +++++++++++++++
 tb/tb_noc_link_tx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/noc_link_tx.sv
// noc_link_tx: credit-based flit transmitter for one NoC link.
// It keeps a credit count that mirrors the free slots in the downstream
// circular_buffer, and it issues a registered write only when a slot is free.
// Once a packet has started, it owns the link until its tail flit.
// Optional build macro: NOC_LINK_TX_STATS_EN adds the flit and stall counters.
// Without the macro, flit_cnt_o and stall_cnt_o are tied to 0.
module noc_link_tx #(
  parameter int BUFFER_SIZE   = 8,
  parameter int DATA_SIZE     = 16,
  parameter int START_CREDITS = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [DATA_SIZE-1:0]               src_data_i,
  input  logic                               src_valid_i,
  input  logic                               src_last_i,
  output logic                               src_ready_o,
  output logic [DATA_SIZE-1:0]               link_data_o,
  output logic                               link_write_en_o,
  input  logic                               credit_return_i,
  output logic [$clog2(BUFFER_SIZE+1)-1:0]   credits_o,
  output logic                               pkt_active_o,
  output logic                               credit_err_o,
  output logic [31:0]                        flit_cnt_o,
  output logic [31:0]                        stall_cnt_o
);

  localparam int CW = $clog2(BUFFER_SIZE + 1);
  localparam logic [CW-1:0] MAX_CREDITS  = CW'(BUFFER_SIZE);
  localparam logic [CW-1:0] HEAD_CREDITS = CW'(START_CREDITS);

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;

  state_t                state_reg, state_next;
  logic [CW-1:0]         credits_reg, credits_next;
  logic                  credit_err_reg, credit_err_next;
  logic [DATA_SIZE-1:0]  link_data_reg;
  logic                  link_write_en_reg;
  logic                  xfer;

  // A transfer happens when the source offers a flit and the link can take it.
  assign xfer = src_valid_i & src_ready_o;

  // Packet FSM and ready. Ready depends only on the state and the registered credits.
  always_comb begin
    state_next  = state_reg;
    src_ready_o = 1'b0;
    case (state_reg)
      IDLE: begin
        // A new head flit needs enough free slots to start a packet.
        src_ready_o = (credits_reg >= HEAD_CREDITS);
        if (xfer && !src_last_i) begin
          state_next = PKT;
        end
      end
      PKT: begin
        // Inside a packet, any free slot is enough for the next flit.
        src_ready_o = (credits_reg != '0);
        if (xfer && src_last_i) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next  = IDLE;
        src_ready_o = 1'b0;
      end
    endcase
  end

  // Credit bookkeeping: a send consumes one credit and a return adds one.
  // A return on a full count saturates the count and raises the sticky error.
  always_comb begin
    credits_next    = credits_reg;
    credit_err_next = credit_err_reg;
    case ({xfer, credit_return_i})
      2'b10: credits_next = credits_reg - 1'b1;
      2'b01: begin
        if (credits_reg == MAX_CREDITS) begin
          credit_err_next = 1'b1;
        end else begin
          credits_next = credits_reg + 1'b1;
        end
      end
      default: credits_next = credits_reg;
    endcase
  end

  // State, credit and error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      credits_reg    <= MAX_CREDITS;
      credit_err_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      credits_reg    <= credits_next;
      credit_err_reg <= credit_err_next;
    end
  end

  // Output stage: the accepted flit goes onto the link one cycle later.
  // The data holds its value between writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      link_data_reg     <= '0;
      link_write_en_reg <= 1'b0;
    end else begin
      link_write_en_reg <= xfer;
      if (xfer) begin
        link_data_reg <= src_data_i;
      end
    end
  end

  assign link_data_o     = link_data_reg;
  assign link_write_en_o = link_write_en_reg;
  assign credits_o       = credits_reg;
  assign pkt_active_o    = (state_reg == PKT);
  assign credit_err_o    = credit_err_reg;

`ifdef NOC_LINK_TX_STATS_EN
  logic [31:0] flit_cnt_reg;
  logic [31:0] stall_cnt_reg;

  // Statistics: count flits sent and cycles where the source is held off.
  // Both counters wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      flit_cnt_reg  <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (xfer) begin
        flit_cnt_reg <= flit_cnt_reg + 32'd1;
      end
      if (src_valid_i && !src_ready_o) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
    end
  end

  assign flit_cnt_o  = flit_cnt_reg;
  assign stall_cnt_o = stall_cnt_reg;
`else
  assign flit_cnt_o  = 32'd0;
  assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_noc_link_tx.sv
// Directed testbench for noc_link_tx.
// The DUT uses BUFFER_SIZE=8, DATA_SIZE=16 and START_CREDITS=4.
module tb_noc_link_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] src_data_i;
  logic        src_valid_i;
  logic        src_last_i;
  logic        src_ready_o;
  logic [15:0] link_data_o;
  logic        link_write_en_o;
  logic        credit_return_i;
  logic [3:0]  credits_o;
  logic        pkt_active_o;
  logic        credit_err_o;
  logic [31:0] flit_cnt_o;
  logic [31:0] stall_cnt_o;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int exp_flit  = 0;
  int exp_stall = 0;
  logic [15:0] exp_data = 16'h0000;
  logic        exp_err  = 1'b0;

  noc_link_tx #(
    .BUFFER_SIZE  (8),
    .DATA_SIZE    (16),
    .START_CREDITS(4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .src_data_i     (src_data_i),
    .src_valid_i    (src_valid_i),
    .src_last_i     (src_last_i),
    .src_ready_o    (src_ready_o),
    .link_data_o    (link_data_o),
    .link_write_en_o(link_write_en_o),
    .credit_return_i(credit_return_i),
    .credits_o      (credits_o),
    .pkt_active_o   (pkt_active_o),
    .credit_err_o   (credit_err_o),
    .flit_cnt_o     (flit_cnt_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_stats(input string tag);
`ifdef NOC_LINK_TX_STATS_EN
    chk({tag, "_flit_cnt"}, flit_cnt_o, exp_flit);
    chk({tag, "_stall_cnt"}, stall_cnt_o, exp_stall);
`else
    chk({tag, "_flit_cnt"}, flit_cnt_o, 32'd0);
    chk({tag, "_stall_cnt"}, stall_cnt_o, 32'd0);
`endif
  endtask

  // Drives one cycle. It checks ready before the edge, then checks the
  // link, credits, packet flag and error flag after the edge.
  task automatic drive_cycle(input string tag, input logic v, input logic last,
                             input logic [15:0] d, input logic cr,
                             input logic exp_ready, input logic [3:0] exp_credits,
                             input logic exp_pkt);
    logic sent;
    src_valid_i     = v;
    src_last_i      = last;
    src_data_i      = d;
    credit_return_i = cr;
    #1;
    chk({tag, "_ready"}, src_ready_o, exp_ready);
    sent = v & exp_ready;
    if (sent) begin
      exp_flit++;
      exp_data = d;
    end
    if (v && !exp_ready) exp_stall++;
    @(posedge clk);
    #1;
    chk({tag, "_wen"}, link_write_en_o, sent);
    chk({tag, "_data"}, link_data_o, exp_data);
    chk({tag, "_credits"}, credits_o, exp_credits);
    chk({tag, "_pkt"}, pkt_active_o, exp_pkt);
    chk({tag, "_err"}, credit_err_o, exp_err);
    $display("cyc %s v=%0b last=%0b d=%h cr=%0b -> wen=%0b data=%h cred=%0d pkt=%0b",
             tag, v, last, d, cr, link_write_en_o, link_data_o, credits_o, pkt_active_o);
  endtask

  initial begin
    reset = 1'b1;
    src_valid_i = 1'b0;
    src_last_i = 1'b0;
    src_data_i = 16'h0;
    credit_return_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_credits", credits_o, 4'd8);
    chk("rst_wen", link_write_en_o, 1'b0);
    chk("rst_data", link_data_o, 16'h0);
    chk("rst_pkt", pkt_active_o, 1'b0);
    chk("rst_err", credit_err_o, 1'b0);
    chk_stats("rst");

    // Ten back-to-back body flits with no returns: only 8 fit.
    for (int i = 0; i < 10; i++) begin
      drive_cycle("burst", 1'b1, 1'b0, 16'hA000 + 16'(i), 1'b0,
                  (i < 8), (i < 8) ? 4'(7 - i) : 4'd0, 1'b1);
    end

    // Drained: one return gives exactly one more flit.
    drive_cycle("ret1", 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 4'd1, 1'b1);
    drive_cycle("one", 1'b1, 1'b0, 16'hB001, 1'b0, 1'b1, 4'd0, 1'b1);
    drive_cycle("dry", 1'b1, 1'b0, 16'hB002, 1'b0, 1'b0, 4'd0, 1'b1);

    // With 3 credits, a body flit is accepted mid-packet but a head flit is not.
    drive_cycle("ret_a", 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 4'd1, 1'b1);
    drive_cycle("ret_b", 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 4'd2, 1'b1);
    drive_cycle("ret_c", 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 4'd3, 1'b1);
    drive_cycle("tail3", 1'b1, 1'b1, 16'hC001, 1'b0, 1'b1, 4'd2, 1'b0);
    drive_cycle("head2", 1'b1, 1'b0, 16'hC002, 1'b1, 1'b0, 4'd3, 1'b0);
    drive_cycle("head3", 1'b1, 1'b0, 16'hC002, 1'b1, 1'b0, 4'd4, 1'b0);
    drive_cycle("head4", 1'b1, 1'b0, 16'hC002, 1'b0, 1'b1, 4'd3, 1'b1);

    // Finish the three-flit packet, then send a single-flit packet.
    drive_cycle("body", 1'b1, 1'b0, 16'hC003, 1'b1, 1'b1, 4'd3, 1'b1);
    drive_cycle("tail", 1'b1, 1'b1, 16'hC004, 1'b1, 1'b1, 4'd3, 1'b0);
    drive_cycle("ret_d", 1'b0, 1'b1, 16'h0, 1'b1, 1'b0, 4'd4, 1'b0);
    drive_cycle("single", 1'b1, 1'b1, 16'hD001, 1'b0, 1'b1, 4'd3, 1'b0);
    drive_cycle("quiet", 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 4'd3, 1'b0);

    // Refill to full, then overflow with one extra return.
    drive_cycle("fill4", 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 4'd4, 1'b0);
    drive_cycle("fill5", 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 4'd5, 1'b0);
    drive_cycle("fill6", 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 4'd6, 1'b0);
    drive_cycle("fill7", 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 4'd7, 1'b0);
    drive_cycle("fill8", 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 4'd8, 1'b0);
    exp_err = 1'b1;
    drive_cycle("ovf", 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 4'd8, 1'b0);
    drive_cycle("sticky", 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 4'd8, 1'b0);

    // Three single flits bring the count to 5. Then a send and a return
    // in the same cycle leave it at 5.
    drive_cycle("s7", 1'b1, 1'b1, 16'hE001, 1'b0, 1'b1, 4'd7, 1'b0);
    drive_cycle("s6", 1'b1, 1'b1, 16'hE002, 1'b0, 1'b1, 4'd6, 1'b0);
    drive_cycle("s5", 1'b1, 1'b1, 16'hE003, 1'b0, 1'b1, 4'd5, 1'b0);
    drive_cycle("net0", 1'b1, 1'b1, 16'hE004, 1'b1, 1'b1, 4'd5, 1'b0);
    chk_stats("mid");

    // Reset in the middle of a packet aborts it and clears everything.
    drive_cycle("start", 1'b1, 1'b0, 16'hF001, 1'b0, 1'b1, 4'd4, 1'b1);
    reset = 1'b1;
    src_valid_i = 1'b1;
    src_last_i = 1'b0;
    src_data_i = 16'hF002;
    credit_return_i = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_err = 1'b0;
    exp_flit = 0;
    exp_stall = 0;
    exp_data = 16'h0;
    chk("rst2_credits", credits_o, 4'd8);
    chk("rst2_pkt", pkt_active_o, 1'b0);
    chk("rst2_wen", link_write_en_o, 1'b0);
    chk("rst2_err", credit_err_o, 1'b0);
    chk("rst2_data", link_data_o, 16'h0);
    chk_stats("rst2");
    drive_cycle("after", 1'b1, 1'b1, 16'hF003, 1'b0, 1'b1, 4'd7, 1'b0);
    chk_stats("end");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
